// File: rtl/dino_pkg.sv
// Shared constants, obstacle sprite encoding and LFSR step for the dino game blocks.
package dino_pkg;

  localparam int          POS_W     = 10;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [2:0]  SPEED_MAX = 3'd6;

  typedef enum logic [1:0] {
    CACTUS_S = 2'd0,
    CACTUS_L = 2'd1,
    BIRD_LO  = 2'd2,
    BIRD_HI  = 2'd3
  } obstacle_type_e;

  // Fibonacci step, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/dino_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; advances on every clk out of reset.
module dino_lfsr
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  // Seed on reset, otherwise step every clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/obstacle_manager.sv
// Two-slot obstacle scroller with randomised spawn gaps and sprite types.
// Define SPEEDUP_EN to raise the scroll speed by one every 8th spawn (max 6).
module obstacle_manager
  import dino_pkg::*;
#(
  parameter int GEN_LINE   = 250,
  parameter int MIN_GAP    = 40,
  parameter int BASE_SPEED = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             crash,
  input  logic             restart,
  output logic [POS_W-1:0] obstacle1_pos,
  output logic [POS_W-1:0] obstacle2_pos,
  output logic [1:0]       obstacle1_type,
  output logic [1:0]       obstacle2_type,
  output logic [2:0]       speed
);

  localparam logic [POS_W-1:0] GEN_POS  = POS_W'(GEN_LINE);
  localparam logic [6:0]       MIN_TGT  = 7'(MIN_GAP);
  localparam logic [2:0]       BASE_SPD = 3'(BASE_SPEED);

  logic [1:0]       act_q, act_d;
  logic [POS_W-1:0] pos_q [2];
  logic [POS_W-1:0] pos_d [2];
  obstacle_type_e   type_q [2];
  obstacle_type_e   type_d [2];
  logic [6:0]       gap_q, gap_d, gap_inc_s;
  logic [6:0]       tgt_q, tgt_d;
  logic [2:0]       speed_q, speed_d;
  logic [15:0]      lfsr_s;
  logic             unused_lfsr_s;
`ifdef SPEEDUP_EN
  logic [2:0]       spawn_cnt_q, spawn_cnt_d;
`endif

  dino_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:6];

  // Next-state: restart beats crash; movement happens first so a freed slot can take the spawn.
  always_comb begin
    act_d     = act_q;
    pos_d     = pos_q;
    type_d    = type_q;
    gap_d     = gap_q;
    tgt_d     = tgt_q;
    speed_d   = speed_q;
    gap_inc_s = (gap_q == 7'd127) ? gap_q : gap_q + 7'd1;
`ifdef SPEEDUP_EN
    spawn_cnt_d = spawn_cnt_q;
`endif
    if (restart) begin
      act_d     = 2'b00;
      pos_d[0]  = '0;
      pos_d[1]  = '0;
      type_d[0] = CACTUS_S;
      type_d[1] = CACTUS_S;
      gap_d     = 7'd0;
      tgt_d     = MIN_TGT;
      speed_d   = BASE_SPD;
`ifdef SPEEDUP_EN
      spawn_cnt_d = 3'd0;
`endif
    end else if (frame_tick && !crash) begin
      for (int i = 0; i < 2; i++) begin
        if (act_q[i] && (pos_q[i] > POS_W'(speed_q))) begin
          act_d[i] = 1'b1;
          pos_d[i] = pos_q[i] - POS_W'(speed_q);
        end else begin
          act_d[i] = 1'b0;
          pos_d[i] = '0;
        end
      end
      if ((gap_inc_s >= tgt_q) && !(act_d[0] && act_d[1])) begin
        if (!act_d[0]) begin
          act_d[0]  = 1'b1;
          pos_d[0]  = GEN_POS;
          type_d[0] = obstacle_type_e'(lfsr_s[1:0]);
        end else begin
          act_d[1]  = 1'b1;
          pos_d[1]  = GEN_POS;
          type_d[1] = obstacle_type_e'(lfsr_s[1:0]);
        end
        gap_d = 7'd0;
        tgt_d = MIN_TGT + {3'b000, lfsr_s[5:2]};
`ifdef SPEEDUP_EN
        spawn_cnt_d = spawn_cnt_q + 3'd1;
        if ((spawn_cnt_q == 3'd7) && (speed_q < SPEED_MAX)) begin
          speed_d = speed_q + 3'd1;
        end else begin
          speed_d = speed_q;
        end
`endif
      end else begin
        gap_d = gap_inc_s;
      end
    end else begin
      act_d = act_q;
      gap_d = gap_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q     <= 2'b00;
      pos_q[0]  <= '0;
      pos_q[1]  <= '0;
      type_q[0] <= CACTUS_S;
      type_q[1] <= CACTUS_S;
      gap_q     <= 7'd0;
      tgt_q     <= MIN_TGT;
      speed_q   <= BASE_SPD;
`ifdef SPEEDUP_EN
      spawn_cnt_q <= 3'd0;
`endif
    end else begin
      act_q   <= act_d;
      pos_q   <= pos_d;
      type_q  <= type_d;
      gap_q   <= gap_d;
      tgt_q   <= tgt_d;
      speed_q <= speed_d;
`ifdef SPEEDUP_EN
      spawn_cnt_q <= spawn_cnt_d;
`endif
    end
  end

  assign obstacle1_pos  = pos_q[0];
  assign obstacle2_pos  = pos_q[1];
  assign obstacle1_type = type_q[0];
  assign obstacle2_type = type_q[1];
  assign speed          = speed_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// Scoreboard bench for obstacle_manager; honours SPEEDUP_EN like the design.
module tb_obstacle_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       crash = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] obstacle1_pos, obstacle2_pos;
  logic [1:0] obstacle1_type, obstacle2_type;
  logic [2:0] speed;

  obstacle_manager #(.GEN_LINE(250), .MIN_GAP(40), .BASE_SPEED(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .crash          (crash),
    .restart        (restart),
    .obstacle1_pos  (obstacle1_pos),
    .obstacle2_pos  (obstacle2_pos),
    .obstacle1_type (obstacle1_type),
    .obstacle2_type (obstacle2_type),
    .speed          (speed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] p1;
    logic [9:0] p2;
    logic [1:0] t1;
    logic [1:0] t2;
    logic [2:0] spd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_pos[2];
  int          m_type[2];
  int          m_gap, m_tgt, m_speed, m_spawns, m_spawn_slot;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clk edge; pos 0 stands for an empty slot.
  task automatic model_edge(input logic tk, input logic cr, input logic rs);
    int g, k;
    m_spawn_slot = -1;
    if (!rst_n) begin
      m_pos[0] = 0; m_pos[1] = 0; m_type[0] = 0; m_type[1] = 0;
      m_gap = 0; m_tgt = 40; m_speed = 2; m_spawns = 0;
      m_lfsr = 16'hACE1;
    end else begin
      if (rs) begin
        m_pos[0] = 0; m_pos[1] = 0; m_type[0] = 0; m_type[1] = 0;
        m_gap = 0; m_tgt = 40; m_speed = 2; m_spawns = 0;
      end else if (tk && !cr) begin
        for (int i = 0; i < 2; i++) begin
          if (m_pos[i] > m_speed) m_pos[i] = m_pos[i] - m_speed;
          else m_pos[i] = 0;
        end
        g = (m_gap + 1 > 127) ? 127 : m_gap + 1;
        if (g >= m_tgt && (m_pos[0] == 0 || m_pos[1] == 0)) begin
          k = (m_pos[0] == 0) ? 0 : 1;
          m_pos[k] = 250;
          m_type[k] = int'(m_lfsr[1:0]);
          m_spawn_slot = k;
          m_gap = 0;
          m_tgt = 40 + int'(m_lfsr[5:2]);
          m_spawns++;
`ifdef SPEEDUP_EN
          if (m_spawns % 8 == 0 && m_speed < 6) m_speed++;
`endif
        end else begin
          m_gap = g;
        end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  endtask

  task automatic step(input logic tk, input logic cr, input logic rs);
    exp_t e;
    exp_t got;
    frame_tick = tk;
    crash      = cr;
    restart    = rs;
    model_edge(tk, cr, rs);
    e.p1  = 10'(m_pos[0]);
    e.p2  = 10'(m_pos[1]);
    e.t1  = 2'(m_type[0]);
    e.t2  = 2'(m_type[1]);
    e.spd = 3'(m_speed);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, speed};
    e = sb.pop_front();
    check("out", int'(got), int'(e));
  endtask

  initial begin
    int e1, e2, n;
    bit seen;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0);
    check("reset_p1", int'(obstacle1_pos), 0);
    check("reset_p2", int'(obstacle2_pos), 0);
    check("reset_speed", int'(speed), 2);

    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    check("spawn_pos", int'(obstacle1_pos), 250);
    check("spawn_type", int'(obstacle1_type), m_type[0]);
    step(1'b1, 1'b0, 1'b0);
    check("first_move", int'(obstacle1_pos), 248);

    // Slot 1 walks down to 2, then expires (or is immediately reused by a pending spawn).
    for (int i = 0; i < 300 && m_pos[0] != 2; i++) step(1'b1, 1'b0, 1'b0);
    check("pos_before_expiry", int'(obstacle1_pos), 2);
    step(1'b1, 1'b0, 1'b0);
    check("expiry_or_reuse", int'(obstacle1_pos), (m_spawn_slot == 0) ? 250 : 0);

    e1 = m_pos[0];
    e2 = m_pos[1];
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    check("freeze_p1", int'(obstacle1_pos), e1);
    check("freeze_p2", int'(obstacle2_pos), e2);
    step(1'b1, 1'b0, 1'b0);
    check("unfreeze_move", int'(obstacle1_pos), (e1 > 2) ? e1 - 2 : m_pos[0]);

    step(1'b1, 1'b0, 1'b1);
    check("restart_p1", int'(obstacle1_pos), 0);
    check("restart_p2", int'(obstacle2_pos), 0);
    check("restart_types", int'({obstacle1_type, obstacle2_type}), 0);
    check("restart_speed", int'(speed), 2);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
      seen = (obstacle1_pos != 10'd0);
    end
    check("restart_gap", n, 40);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) == 0));

    step(1'b1, 1'b1, 1'b1);
    check("restart_over_crash", int'({obstacle1_pos, obstacle2_pos}), 0);

`ifdef SPEEDUP_EN
    for (int i = 0; i < 5000 && m_spawns < 8; i++) step(1'b1, 1'b0, 1'b0);
    check("speed_8th", int'(speed), 3);
    for (int i = 0; i < 20000 && m_spawns < 32; i++) step(1'b1, 1'b0, 1'b0);
    check("speed_32nd", int'(speed), 6);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
    check("speed_sat", int'(speed), 6);
    step(1'b0, 1'b0, 1'b1);
    check("speed_restart", int'(speed), 2);
`else
    for (int i = 0; i < 600; i++) step(1'b1, 1'b0, 1'b0);
    check("speed_const", int'(speed), 2);
`endif

    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    check("midrun_reset_pos", int'({obstacle1_pos, obstacle2_pos}), 0);
    check("midrun_reset_speed", int'(speed), 2);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
